// File: rtl/pipe_stage_skid_if.sv
// Handshake, payload and statistics bundle for one pipeline-stage boundary.
interface pipe_stage_skid_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  // Stage-side view.
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cycles, flush_count
  );

  // Surrounding-pipeline view.
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer, flush and
// saturating stall/flush statistics. in_ready depends on state only.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            r_state,     w_state_d;
  logic [CTRL_W-1:0] r_main_ctrl, w_main_ctrl_d;
  logic [DATA_W-1:0] r_main_data, w_main_data_d;
  logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_d;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_d;
  logic [CNT_W-1:0]  r_stall,     w_stall_d;
  logic [CNT_W-1:0]  r_flushes,   w_flushes_d;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;

  // Handshake decode; in_ready comes from the state register alone.
  always_comb begin
    w_in_ready  = (r_state != StTwo);
    w_out_valid = (r_state != StEmpty);
    w_in_fire   = bus.in_valid && w_in_ready;
    w_out_fire  = w_out_valid && bus.out_ready;
  end

  // Next state and payload movement; flush overrides both handshakes.
  always_comb begin
    w_state_d     = r_state;
    w_main_ctrl_d = r_main_ctrl;
    w_main_data_d = r_main_data;
    w_skid_ctrl_d = r_skid_ctrl;
    w_skid_data_d = r_skid_data;
    if (bus.flush) begin
      // Data registers keep their value; only ctrl is squashed.
      w_state_d     = StEmpty;
      w_main_ctrl_d = '0;
      w_skid_ctrl_d = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_d     = StOne;
            w_main_ctrl_d = bus.in_ctrl;
            w_main_data_d = bus.in_data;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_ctrl_d = bus.in_ctrl;
            w_main_data_d = bus.in_data;
          end else if (w_out_fire) begin
            w_state_d     = StEmpty;
            w_main_ctrl_d = '0;
          end else if (w_in_fire) begin
            w_state_d     = StTwo;
            w_skid_ctrl_d = bus.in_ctrl;
            w_skid_data_d = bus.in_data;
          end
        end
        StTwo: begin
          if (w_out_fire) begin
            w_state_d     = StOne;
            w_main_ctrl_d = r_skid_ctrl;
            w_main_data_d = r_skid_data;
            w_skid_ctrl_d = '0;
          end
        end
        default: begin
          w_state_d     = StEmpty;
          w_main_ctrl_d = '0;
          w_skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Saturating statistics counters.
  always_comb begin
    w_stall_d   = r_stall;
    w_flushes_d = r_flushes;
    if (w_out_valid && !bus.out_ready && !bus.flush && (r_stall != '1)) begin
      w_stall_d = r_stall + CNT_W'(1);
    end
    if (bus.flush && (r_state != StEmpty) && (r_flushes != '1)) begin
      w_flushes_d = r_flushes + CNT_W'(1);
    end
  end

  // State, payload and counter registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StEmpty;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_stall     <= '0;
      r_flushes   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_main_ctrl <= w_main_ctrl_d;
      r_main_data <= w_main_data_d;
      r_skid_ctrl <= w_skid_ctrl_d;
      r_skid_data <= w_skid_data_d;
      r_stall     <= w_stall_d;
      r_flushes   <= w_flushes_d;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_ctrl     = r_main_ctrl;
  assign bus.out_data     = r_main_data;
  assign bus.occupancy    = r_state;
  assign bus.stall_cycles = r_stall;
  assign bus.flush_count  = r_flushes;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(128), .CNT_W(16)) bif ();
  pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(128), .CNT_W(4))  bif4 ();

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(128), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif.slave)
  );

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(128), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held entries plus the counters.
  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
  } ent_t;

  ent_t         m_q[$];
  logic [127:0] m_last  = '0;
  int unsigned  m_stall = 0;
  int unsigned  m_flush = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_last  = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (bif.flush) begin
        if (m_q.size() != 0 && m_flush < 65535) m_flush++;
        m_q.delete();
      end else begin
        bit of, inf;
        of  = (m_q.size() != 0) && bif.out_ready;
        inf = bif.in_valid && (m_q.size() < 2);
        if (m_q.size() != 0 && !bif.out_ready && m_stall < 65535) m_stall++;
        if (of) void'(m_q.pop_front());
        if (inf) m_q.push_back('{c: bif.in_ctrl, d: bif.in_data});
      end
      // The head register shows the most recent head entry, even once drained.
      if (m_q.size() != 0) m_last = m_q[0].d;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      int sz;
      sz = m_q.size();
      chk("out_valid", 128'(bif.out_valid), 128'(sz != 0));
      chk("in_ready", 128'(bif.in_ready), 128'(sz < 2));
      chk("occupancy", 128'(bif.occupancy), 128'(sz));
      chk("out_ctrl", 128'(bif.out_ctrl), (sz != 0) ? 128'(m_q[0].c) : 128'(0));
      chk("out_data", bif.out_data, (sz != 0) ? m_q[0].d : m_last);
      chk("stall_cycles", 128'(bif.stall_cycles), 128'(m_stall));
      chk("flush_count", 128'(bif.flush_count), 128'(m_flush));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] d_a;

  initial begin
    bif.flush = 0; bif.in_valid = 0; bif.in_ctrl = 0; bif.in_data = 0; bif.out_ready = 0;
    bif4.flush = 0; bif4.in_valid = 0; bif4.in_ctrl = 0; bif4.in_data = 0; bif4.out_ready = 0;
    cyc(); cyc();
    chk("rst_out_valid", 128'(bif.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bif.in_ready), 128'(1));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Streaming at full rate.
    bif.out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      bif.in_valid = 1; bif.in_ctrl = 8'(i); bif.in_data = rnd128();
      cyc();
      chk("stream_ctrl", 128'(bif.out_ctrl), 128'(i));
      chk("stream_in_ready", 128'(bif.in_ready), 128'(1));
    end
    bif.in_valid = 0;
    cyc();
    chk("stream_drained", 128'(bif.out_valid), 128'(0));

    // Back-pressure: A, B fill the stage, C waits.
    bif.out_ready = 0;
    bif.in_valid = 1; bif.in_ctrl = 8'hA1; bif.in_data = rnd128();
    cyc();
    bif.in_ctrl = 8'hB2; bif.in_data = rnd128();
    cyc();
    chk("bp_occ", 128'(bif.occupancy), 128'(2));
    bif.in_ctrl = 8'hC3; bif.in_data = rnd128();
    cyc();
    chk("bp_in_ready", 128'(bif.in_ready), 128'(0));
    chk("bp_head_a", 128'(bif.out_ctrl), 128'(8'hA1));
    cyc();
    chk("bp_stall", 128'(bif.stall_cycles), 128'(3));
    bif.out_ready = 1;
    cyc();
    chk("bp_head_b", 128'(bif.out_ctrl), 128'(8'hB2));
    cyc();
    chk("bp_head_c", 128'(bif.out_ctrl), 128'(8'hC3));
    bif.in_valid = 0;
    cyc();
    chk("bp_stall_final", 128'(bif.stall_cycles), 128'(3));

    // Flush while full; the presented entry D must never appear.
    bif.out_ready = 0;
    d_a = rnd128();
    bif.in_valid = 1; bif.in_ctrl = 8'hA1; bif.in_data = d_a;
    cyc();
    bif.in_ctrl = 8'hB2; bif.in_data = rnd128();
    cyc();
    bif.flush = 1; bif.in_ctrl = 8'hD4; bif.in_data = rnd128();
    cyc();
    chk("fl_out_valid", 128'(bif.out_valid), 128'(0));
    chk("fl_out_ctrl", 128'(bif.out_ctrl), 128'(0));
    chk("fl_out_data", bif.out_data, d_a);
    chk("fl_count", 128'(bif.flush_count), 128'(1));
    chk("fl_in_ready", 128'(bif.in_ready), 128'(1));
    chk("fl_stall", 128'(bif.stall_cycles), 128'(4));
    bif.flush = 0; bif.in_valid = 0;
    cyc();
    chk("fl_no_d", 128'(bif.out_valid), 128'(0));

    // Flush while empty leaves the count alone.
    bif.flush = 1;
    cyc();
    bif.flush = 0;
    chk("fl_empty_count", 128'(bif.flush_count), 128'(1));

    // Counter saturation on the narrow instance.
    bif4.in_valid = 1; bif4.in_ctrl = 8'h55;
    cyc();
    bif4.in_valid = 0;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_stall", 128'(bif4.stall_cycles), 128'(15));
    cyc(); cyc();
    chk("sat_stall_hold", 128'(bif4.stall_cycles), 128'(15));

    // Reset mid-stream, checked before any clock edge.
    bif.out_ready = 0;
    bif.in_valid = 1; bif.in_ctrl = 8'h11; bif.in_data = rnd128();
    cyc();
    bif.in_ctrl = 8'h22; bif.in_data = rnd128();
    cyc();
    bif.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(bif.out_valid), 128'(0));
    chk("mrst_out_ctrl", 128'(bif.out_ctrl), 128'(0));
    chk("mrst_out_data", bif.out_data, 128'(0));
    chk("mrst_occ", 128'(bif.occupancy), 128'(0));
    chk("mrst_stall", 128'(bif.stall_cycles), 128'(0));
    chk("mrst_flush", 128'(bif.flush_count), 128'(0));
    chk("mrst_sat_stall", 128'(bif4.stall_cycles), 128'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bif.in_valid  = ($urandom_range(0, 3) != 0);
      bif.out_ready = ($urandom_range(0, 2) != 0);
      bif.flush     = ($urandom_range(0, 40) == 0);
      bif.in_ctrl   = 8'($urandom);
      bif.in_data   = rnd128();
      cyc();
    end
    bif.flush = 0; bif.in_valid = 0; bif.out_ready = 1;
    cyc(); cyc();

    @(posedge clk);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
